seven_seg: RTL and testbench
============================

// Module: seven_seg
// PURPOSE
//   Hex-digit to seven-segment display driver for the board's common-anode
//   displays. Decodes a 4-bit value 0x0..0xF into the glyphs 0-9, A, b, C, d, E, F.
//   Output is registered, giving one clock of latency.
//   Sits between the game-logic value registers and the HEX display pins.
// PARAMETERS
//   ACTIVE_LOW  1  1: segment lit when its bit is 0 (board default); 0: inverted polarity
// PORTS
//   clk         in   1  system clock; single clock domain, rising edge
//   rst         in   1  asynchronous, active-low reset
//   Seg_in      in   4  hex digit to display
//   blank       in   1  1 = all segments dark
//   lamp_test   in   1  1 = all segments lit
//   Seg_out     out  7  segment drive {g,f,e,d,c,b,a}, bit 0 = a
// BEHAVIOUR
//   - The block is reset by one clock and one reset only: clk, and rst, which is
//     asynchronous and active-low.
//   - Reset: while rst=0, Seg_out is forced to the all-dark code immediately.
//     All-dark is 7'h7F when ACTIVE_LOW=1 and 7'h00 when ACTIVE_LOW=0.
//   - Latency: Seg_out is updated on each rising clk edge from the inputs sampled
//     at that edge. This is one cycle of latency, and there is no handshake.
//   - Priority, highest first: lamp_test, then blank, then decode.
//     - lamp_test=1: all lit (7'h00 active-low).
//     - blank=1: all dark.
//     - Otherwise: decoded glyph.
//   - Glyph table, active-high {g..a}:
//     - 0=3F  1=06  2=5B  3=4F  4=66  5=6D  6=7D  7=07
//     - 8=7F  9=6F  A=77  b=7C  C=39  d=5E  E=79  F=71
//   - ACTIVE_LOW=1 outputs the bitwise inverse of the table. Examples: 0 -> 7'h40,
//     8 -> 7'h00, F -> 7'h0E.
//   - Every one of the 16 input codes maps to a defined glyph; there are no
//     don't-cares.
//   - X/Z on Seg_in is not decoded specially. A default branch drives all-dark.
//   - Asserting rst mid-operation clears Seg_out asynchronously. The first edge
//     after rst deasserts loads the decode of the current inputs.
//   - Simultaneous lamp_test and blank: lamp_test wins.
// STRUCTURE
//   - Package seven_seg_pkg holds:
//     - localparam glyph constants GLYPH_0..GLYPH_F (active-high, 7 bits)
//     - SEG_ALL_ON and SEG_ALL_OFF
//     - function seg_polarity(glyph, active_low)
//   - Sub-module seven_seg_rom (combinational): 4-bit in -> 7-bit active-high
//     glyph, using a full case statement.
//   - Top level: override mux, polarity inversion and the output register with
//     async reset.
// TESTING
//   1. Hold rst=0 with Seg_in=4'h8 -> Seg_out=7'h7F throughout.
//      Release rst -> 7'h00 one edge later.
//   2. Sweep Seg_in 0..F, one value per clock, blank=0, lamp_test=0.
//      -> Seg_out one cycle later is 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
//   3. Seg_in=4'h5 with blank=1 -> 7'h7F. Drop blank -> 7'h12 next edge.
//   4. lamp_test=1 and blank=1 with Seg_in=4'h1 -> 7'h00.
//      Drop lamp_test -> 7'h7F. Drop blank -> 7'h79.
//   5. Assert rst between clock edges while displaying 4'h3 (7'h30).
//      -> Seg_out=7'h7F immediately, without waiting for a clk edge.
//   6. Rebuild with ACTIVE_LOW=0 and Seg_in=4'h0 -> 7'h3F. Reset -> 7'h00.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared glyph constants and polarity helper for the seven-segment display driver.
// Glyphs are active-high {g,f,e,d,c,b,a}, bit 0 = a.
package seven_seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [6:0] SEG_ALL_ON  = 7'h7F;
  localparam logic [6:0] SEG_ALL_OFF = 7'h00;

  // Maps an active-high pattern onto the pin polarity of the display.
  function automatic logic [6:0] seg_polarity(input logic [6:0] glyph, input logic active_low);
    return active_low ? ~glyph : glyph;
  endfunction

endpackage

// File: rtl/seven_seg_rom.sv
// Combinational hex-digit to active-high seven-segment glyph lookup.
module seven_seg_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_ALL_OFF;
    case (digit)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      // Only reachable with X/Z on the input: show nothing rather than garbage.
      default: glyph = SEG_ALL_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg.sv
// Seven-segment display driver: lamp-test/blank override, pin polarity and a
// registered output (one clock of latency) cleared asynchronously by rst.
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Seg_in,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] Seg_out
);

  localparam logic [6:0] SEG_DARK = seg_polarity(SEG_ALL_OFF, ACTIVE_LOW);

  logic [6:0] glyph_p0;
  logic [6:0] sel_p0;
  logic [6:0] drive_p0;
  logic [6:0] seg_p1;

  seven_seg_rom u_rom (
    .digit (Seg_in),
    .glyph (glyph_p0)
  );

  // Stage p0: override mux (lamp_test beats blank beats decode), then polarity.
  always_comb begin
    sel_p0 = glyph_p0;
    if (lamp_test) begin
      sel_p0 = SEG_ALL_ON;
    end else if (blank) begin
      sel_p0 = SEG_ALL_OFF;
    end
    drive_p0 = seg_polarity(sel_p0, ACTIVE_LOW);
  end

  // Stage p1: output register; rst is active-low and asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_p1 <= SEG_DARK;
    end else begin
      seg_p1 <= drive_p0;
    end
  end

  assign Seg_out = seg_p1;

endmodule

// File: tb/tb_seven_seg.sv
// Scoreboard bench for seven_seg: drives both polarities in parallel and
// checks every registered output against hand-written expected codes.
module tb_seven_seg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Seg_in;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg_al;
  logic [6:0] seg_ah;
  logic       done = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [6:0] al;
    logic [6:0] ah;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  seven_seg #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk       (clk),
    .rst       (rst),
    .Seg_in    (Seg_in),
    .blank     (blank),
    .lamp_test (lamp_test),
    .Seg_out   (seg_al)
  );

  seven_seg #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk       (clk),
    .rst       (rst),
    .Seg_in    (Seg_in),
    .blank     (blank),
    .lamp_test (lamp_test),
    .Seg_out   (seg_ah)
  );

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 7'h%02h expected 7'h%02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] d, input logic b, input logic lt,
                      input logic [6:0] al, input logic [6:0] ah, input string nm);
    exp_t e;
    @(negedge clk);
    Seg_in    = d;
    blank     = b;
    lamp_test = lt;
    e.name = nm;
    e.al   = al;
    e.ah   = ah;
    q.push_back(e);
  endtask

  // Monitor: during reset both outputs must be dark; otherwise each edge
  // retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst or posedge done);
      if (done) break;
      #1;
      if (rst === 1'b0) begin
        chk("reset_al", seg_al, 7'h7F);
        chk("reset_ah", seg_ah, 7'h00);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, "_al"}, seg_al, e.al);
        chk({e.name, "_ah"}, seg_ah, e.ah);
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  logic [6:0] sweep_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] sweep_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  initial begin
    exp_t e;
    rst       = 1'b0;
    Seg_in    = 4'h8;
    blank     = 1'b0;
    lamp_test = 1'b0;

    // Reset held with an 8 on the input, then released.
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    e.name = "rst_release";
    e.al   = 7'h00;
    e.ah   = 7'h7F;
    q.push_back(e);

    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b0, 1'b0, sweep_al[i], sweep_ah[i], $sformatf("sweep_%0h", i));
    end

    step(4'h5, 1'b1, 1'b0, 7'h7F, 7'h00, "blank5");
    step(4'h5, 1'b0, 1'b0, 7'h12, 7'h6D, "unblank5");

    step(4'h1, 1'b1, 1'b1, 7'h00, 7'h7F, "lt_and_blank");
    step(4'h1, 1'b1, 1'b0, 7'h7F, 7'h00, "blank_only");
    step(4'h1, 1'b0, 1'b0, 7'h79, 7'h06, "decode1");
    step(4'hA, 1'b0, 1'b1, 7'h00, 7'h7F, "lt_only");

    // Reset asserted mid-cycle; the monitor checks darkness before any clk edge.
    step(4'h3, 1'b0, 1'b0, 7'h30, 7'h4F, "show3");
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    e.name = "rst_rel3";
    e.al   = 7'h30;
    e.ah   = 7'h4F;
    q.push_back(e);

    step(4'h0, 1'b0, 1'b0, 7'h40, 7'h3F, "zero");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    done = 1'b1;
  end

endmodule
